sdhci_dat_xfer_ctrl: RTL and testbench
======================================

# sdhci_dat_xfer_ctrl

Data-transfer sequencer for the SDHCI single-slot host, directly upstream of the register logic. It turns a data command into block-by-block handshakes between the host-side block buffer and the SD data-line engine. It drives the present-state transfer flags (read/write transfer active, buffer read/write enable) and the hardware write of block count. The register logic consumes these flags and derives dat_line_active, command_inhibit_dat, the buffer-ready interrupts and transfer_complete from them.

## Interface
- No parameters.
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- abort_i  in  1  software DAT reset / abort; synchronous clear, same effect as rst_i.
- start_i  in  1  one-cycle pulse: data command issued; samples configuration inputs.
- dir_read_i  in  1  1 = card-to-host, 0 = host-to-card.
- multi_block_i  in  1  multi/single block select.
- block_count_enable_i  in  1  block count enable.
- auto_cmd12_enable_i  in  1  auto CMD12 enable.
- block_count_i  in  16  block count register value, after inhibit gating.
- block_size_i  in  12  transfer block size in bytes.
- word_access_i  in  1  one-cycle pulse per 32-bit host access to the buffer data port.
- line_block_done_i  in  1  pulse: data-line engine finished one block (read: block in buffer; write: CRC status received).
- line_error_i  in  1  pulse: data timeout, CRC or end-bit error on the line.
- line_start_o  out  1  pulse: start one block on the data line.
- read_transfer_active_o  out  1  present_state.read_transfer_active.
- write_transfer_active_o  out  1  present_state.write_transfer_active.
- buffer_read_enable_o  out  1  present_state.buffer_read_enable.
- buffer_write_enable_o  out  1  present_state.buffer_write_enable.
- block_count_o  out  writable_reg_t([15:0])  .d = new count, .de = one-cycle write strobe.
- auto_cmd12_req_o  out  1  pulse: request auto CMD12 to the command engine.

## Operation
- FSM states: IDLE, WR_BUF, WR_LINE, RD_LINE, RD_BUF, FINISH.
- start_i is honoured only in IDLE; it is ignored elsewhere.
- start_i is also ignored if block_size_i == 0, or if multi_block_i & block_count_enable_i & block_count_i == 0.
- On an accepted start, the block latches all configuration inputs.
  - remaining := block_count_i.
  - words := (block_size_i + 3) >> 2, giving 1..1024.
- Write path:
  - IDLE → WR_BUF.
  - WR_BUF: buffer_write_enable_o = 1. Count word_access_i pulses. When the count reaches words, go to WR_LINE.
  - WR_LINE: pulse line_start_o on the entry cycle, then wait for line_block_done_i.
- Read path:
  - IDLE → RD_LINE.
  - RD_LINE: pulse line_start_o on entry and wait for line_block_done_i. Then go to RD_BUF.
  - RD_BUF: buffer_read_enable_o = 1. Count words; block completion occurs when the count reaches words.
- Block completion (write: line_block_done_i in WR_LINE; read: last word in RD_BUF):
  - If block_count_enable_i is latched 1, pulse block_count_o.de with .d = remaining − 1 and decrement remaining.
  - A block is the last block when multi_block_i is latched 0, or when block_count_enable_i is latched 1 and remaining == 1 before the decrement.
  - If multi_block_i = 1 and block_count_enable_i = 0, the transfer is unbounded and ends only on abort_i or line_error_i.
  - If this is not the last block, go back to WR_BUF or RD_LINE. If it is the last block, go to FINISH.
- FINISH lasts one cycle, then the FSM returns to IDLE. The auto CMD12 pulse is issued here (see Configuration).
- read_transfer_active_o is 1 in RD_LINE, RD_BUF and FINISH of a read.
- write_transfer_active_o is 1 in WR_BUF, WR_LINE and FINISH of a write.
- line_error_i in any non-IDLE state:
  - Go to IDLE next cycle and clear all flags.
  - No block count write and no auto CMD12.
- Word accesses outside the enabled buffer state are ignored.
- Word counter: 11 bits, cleared on every block boundary.

## Timing
- Reset and abort values: all outputs 0, state IDLE, counters 0.
- The transfer-active flag rises the cycle after start_i.
- line_start_o asserts exactly one cycle, on the first cycle of a LINE state.
- buffer_write_enable_o falls in the cycle after the final word_access_i.
- buffer_read_enable_o falls in the cycle after the final word_access_i.
- block_count_o.de fires in the cycle after the completing event and is a single-cycle pulse.
- The active flag falls 2 cycles after the last completing event (via FINISH), i.e. after block_count_o.de.
- Simultaneous line_error_i and line_block_done_i: the error wins.
- Simultaneous abort_i and rst_i with anything else: the reset wins.

## Configuration
- SDHCI_AUTO_CMD12_EN defined:
  - In FINISH, auto_cmd12_req_o pulses for one cycle when both multi_block_i and auto_cmd12_enable_i were latched 1.
  - It never pulses on error or abort.
- SDHCI_AUTO_CMD12_EN undefined:
  - auto_cmd12_req_o is tied 0.
  - auto_cmd12_enable_i is unused.

## Test plan
- Single-block write, size 512:
  - Stimulus: start with dir 0.
  - buffer_write_enable_o stays high for exactly 128 word pulses, then line_start_o pulses once.
  - After line_block_done_i, no block_count_o.de (count enable 0) and write_transfer_active_o falls 2 cycles later.
- Multi-block read, count 3, size 4, count enable 1:
  - Three line_start_o / RD_BUF cycles, each RD_BUF taking 1 word.
  - block_count_o.d goes 2, 1, 0.
  - With SDHCI_AUTO_CMD12_EN and auto_cmd12_enable_i = 1, auto_cmd12_req_o pulses once in FINISH.
- Odd block size 5:
  - words = 2.
  - The buffer enable drops only after the 2nd word access.
- Illegal starts:
  - block_size_i = 0 → remains IDLE, all outputs 0.
  - Multi-block with count enable and count 0 → remains IDLE, all outputs 0.
- line_error_i during block 2 of 4:
  - FSM goes to IDLE next cycle with all flags 0.
  - block_count_o.de pulsed only once, and auto_cmd12_req_o stays 0.
- abort_i mid-WR_BUF, with a start_i in the same cycle and a word pulse in the next cycle:
  - Outputs clear; the start is ignored and the word pulse is ignored.
  - A subsequent clean start behaves as a fresh transfer.

Source files
------------

// File: rtl/sdhci_dat_xfer_ctrl.sv
// SDHCI data-transfer sequencer: block-by-block buffer/data-line handshakes and present-state flags.
// Optional feature macro: SDHCI_AUTO_CMD12_EN (auto CMD12 request at the end of a multi-block run).

package sdhci_dat_xfer_pkg;
    typedef struct packed {
        logic [15:0] d;
        logic        de;
    } writable_reg_t;
endpackage

module sdhci_dat_xfer_ctrl
    import sdhci_dat_xfer_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic          dir_read_i,
    input  logic          multi_block_i,
    input  logic          block_count_enable_i,
    input  logic          auto_cmd12_enable_i,
    input  logic [15:0]   block_count_i,
    input  logic [11:0]   block_size_i,
    input  logic          word_access_i,
    input  logic          line_block_done_i,
    input  logic          line_error_i,
    output logic          line_start_o,
    output logic          read_transfer_active_o,
    output logic          write_transfer_active_o,
    output logic          buffer_read_enable_o,
    output logic          buffer_write_enable_o,
    output writable_reg_t block_count_o,
    output logic          auto_cmd12_req_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWrBuf,
        StWrLine,
        StRdLine,
        StRdBuf,
        StFinish
    } state_e;

    state_e        state_q, state_d;
    logic          dir_read_q, dir_read_d;
    logic          multi_q, multi_d;
    logic          bce_q, bce_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [10:0]   words_q, words_d;
    logic [10:0]   word_cnt_q, word_cnt_d;
    logic          line_start_q, line_start_d;
    writable_reg_t bc_q, bc_d;
    logic          acmd_req_q, acmd_req_d;
    logic          acmd_en_q, acmd_en_d;

    logic start_ok;
    logic block_done;
    logic is_last;
    logic last_word;

    assign start_ok = start_i && (block_size_i != 12'd0) &&
                      !(multi_block_i && block_count_enable_i && (block_count_i == 16'd0));
    // Unbounded multi-block (count enable off) never reaches a last block.
    assign is_last   = !multi_q || (bce_q && (remaining_q == 16'd1));
    assign last_word = (11'(word_cnt_q + 11'd1) == words_q);

    always_comb begin
        state_d      = state_q;
        dir_read_d   = dir_read_q;
        multi_d      = multi_q;
        bce_d        = bce_q;
        remaining_d  = remaining_q;
        words_d      = words_q;
        word_cnt_d   = word_cnt_q;
        acmd_en_d    = acmd_en_q;
        bc_d.d       = bc_q.d;
        bc_d.de      = 1'b0;
        acmd_req_d   = 1'b0;
        line_start_d = 1'b0;
        block_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    dir_read_d  = dir_read_i;
                    multi_d     = multi_block_i;
                    bce_d       = block_count_enable_i;
`ifdef SDHCI_AUTO_CMD12_EN
                    acmd_en_d   = auto_cmd12_enable_i;
`endif
                    remaining_d = block_count_i;
                    words_d     = 11'((13'(block_size_i) + 13'd3) >> 2);
                    word_cnt_d  = 11'd0;
                    state_d     = dir_read_i ? StRdLine : StWrBuf;
                end
            end
            StWrBuf: begin
                if (word_access_i) begin
                    if (last_word) begin
                        word_cnt_d = 11'd0;
                        state_d    = StWrLine;
                    end else begin
                        word_cnt_d = 11'(word_cnt_q + 11'd1);
                    end
                end
            end
            StWrLine: begin
                if (line_block_done_i) begin
                    block_done = 1'b1;
                end
            end
            StRdLine: begin
                if (line_block_done_i) begin
                    word_cnt_d = 11'd0;
                    state_d    = StRdBuf;
                end
            end
            StRdBuf: begin
                if (word_access_i) begin
                    if (last_word) begin
                        word_cnt_d = 11'd0;
                        block_done = 1'b1;
                    end else begin
                        word_cnt_d = 11'(word_cnt_q + 11'd1);
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (block_done) begin
            if (bce_q) begin
                bc_d.d      = 16'(remaining_q - 16'd1);
                bc_d.de     = 1'b1;
                remaining_d = 16'(remaining_q - 16'd1);
            end
            if (is_last) begin
                state_d = StFinish;
            end else begin
                state_d = dir_read_q ? StRdLine : StWrBuf;
            end
        end

        // A line error overrides any completion in the same cycle.
        if ((state_q != StIdle) && line_error_i) begin
            state_d     = StIdle;
            bc_d.d      = bc_q.d;
            bc_d.de     = 1'b0;
            remaining_d = remaining_q;
            word_cnt_d  = 11'd0;
        end

        line_start_d = ((state_d == StWrLine) || (state_d == StRdLine)) && (state_d != state_q);

`ifdef SDHCI_AUTO_CMD12_EN
        acmd_req_d = (state_d == StFinish) && (state_q != StFinish) && multi_q && acmd_en_q;
`endif
    end

`ifndef SDHCI_AUTO_CMD12_EN
    logic unused_auto_cmd12_enable;
    assign unused_auto_cmd12_enable = auto_cmd12_enable_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            state_q      <= StIdle;
            dir_read_q   <= 1'b0;
            multi_q      <= 1'b0;
            bce_q        <= 1'b0;
            remaining_q  <= 16'd0;
            words_q      <= 11'd0;
            word_cnt_q   <= 11'd0;
            line_start_q <= 1'b0;
            bc_q         <= '0;
            acmd_req_q   <= 1'b0;
            acmd_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_read_q   <= dir_read_d;
            multi_q      <= multi_d;
            bce_q        <= bce_d;
            remaining_q  <= remaining_d;
            words_q      <= words_d;
            word_cnt_q   <= word_cnt_d;
            line_start_q <= line_start_d;
            bc_q         <= bc_d;
            acmd_req_q   <= acmd_req_d;
            acmd_en_q    <= acmd_en_d;
        end
    end

    assign line_start_o            = line_start_q;
    assign block_count_o           = bc_q;
    assign auto_cmd12_req_o        = acmd_req_q;
    assign buffer_write_enable_o   = (state_q == StWrBuf);
    assign buffer_read_enable_o    = (state_q == StRdBuf);
    assign read_transfer_active_o  = (state_q == StRdLine) || (state_q == StRdBuf) ||
                                     ((state_q == StFinish) && dir_read_q);
    assign write_transfer_active_o = (state_q == StWrBuf) || (state_q == StWrLine) ||
                                     ((state_q == StFinish) && !dir_read_q);

endmodule

// File: tb/tb_sdhci_dat_xfer_ctrl.sv
// Randomised scoreboard bench for sdhci_dat_xfer_ctrl; honours SDHCI_AUTO_CMD12_EN if defined.

module tb_sdhci_dat_xfer_ctrl;
    import sdhci_dat_xfer_pkg::*;

`ifdef SDHCI_AUTO_CMD12_EN
    localparam bit AcmdBuilt = 1'b1;
`else
    localparam bit AcmdBuilt = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          abort_i = 1'b0;
    logic          start_i = 1'b0;
    logic          dir_read_i = 1'b0;
    logic          multi_block_i = 1'b0;
    logic          block_count_enable_i = 1'b0;
    logic          auto_cmd12_enable_i = 1'b0;
    logic [15:0]   block_count_i = '0;
    logic [11:0]   block_size_i = '0;
    logic          word_access_i = 1'b0;
    logic          line_block_done_i = 1'b0;
    logic          line_error_i = 1'b0;
    logic          line_start_o;
    logic          rta, wta, bre, bwe;
    writable_reg_t bc;
    logic          acmd;

    int vectors = 0;
    int errors  = 0;

    // Expected events; ls/ac store expected {read_active, write_active}, bcq stores expected .d
    int          lsq[$];
    int          acq[$];
    logic [15:0] bcq[$];

    sdhci_dat_xfer_ctrl dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .abort_i                (abort_i),
        .start_i                (start_i),
        .dir_read_i             (dir_read_i),
        .multi_block_i          (multi_block_i),
        .block_count_enable_i   (block_count_enable_i),
        .auto_cmd12_enable_i    (auto_cmd12_enable_i),
        .block_count_i          (block_count_i),
        .block_size_i           (block_size_i),
        .word_access_i          (word_access_i),
        .line_block_done_i      (line_block_done_i),
        .line_error_i           (line_error_i),
        .line_start_o           (line_start_o),
        .read_transfer_active_o (rta),
        .write_transfer_active_o(wta),
        .buffer_read_enable_o   (bre),
        .buffer_write_enable_o  (bwe),
        .block_count_o          (bc),
        .auto_cmd12_req_o       (acmd)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_rta"}, int'(rta), 0);
        check({name, "_wta"}, int'(wta), 0);
        check({name, "_bre"}, int'(bre), 0);
        check({name, "_bwe"}, int'(bwe), 0);
        check({name, "_line_start"}, int'(line_start_o), 0);
        check({name, "_bc_de"}, int'(bc.de), 0);
        check({name, "_acmd"}, int'(acmd), 0);
    endtask

    // Monitor: every output event must match the head of its expectation queue.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (line_start_o) begin
                if (lsq.size() == 0) check("line_start_unexpected", 1, 0);
                else check("line_start_flags", int'({rta, wta}), lsq.pop_front());
            end
            if (bc.de) begin
                if (bcq.size() == 0) check("bc_de_unexpected", 1, 0);
                else check("bc_d", int'(bc.d), int'(bcq.pop_front()));
            end
            if (acmd) begin
                if (acq.size() == 0) check("acmd_unexpected", 1, 0);
                else check("acmd_flags", int'({rta, wta}), acq.pop_front());
            end
        end
    end

    task automatic do_words(input int words, input bit rd);
        for (int w = 0; w < words; w++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (w == words - 1) check(rd ? "bre_hold" : "bwe_hold", int'(rd ? bre : bwe), 1);
            word_access_i = 1'b1;
            tick();
            word_access_i = 1'b0;
        end
        check(rd ? "bre_fall" : "bwe_fall", int'(rd ? bre : bwe), 0);
    endtask

    // Reference transfer: err_blk >= 0 injects an error (with a coincident done) on that block.
    task automatic run_xfer(input bit d, input bit m, input bit be, input bit ae, input int count,
                            input int sz, input int nblk, input int err_blk);
        int words;
        int rem;
        int flags;
        bit last;
        words = (sz + 3) / 4;
        rem   = count;
        flags = d ? 2 : 1;
        dir_read_i = d;
        multi_block_i = m;
        block_count_enable_i = be;
        auto_cmd12_enable_i = ae;
        block_count_i = 16'(count);
        block_size_i = 12'(sz);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("active_rise", int'({rta, wta}), flags);
        if (d) lsq.push_back(flags);
        for (int b = 0; b < nblk; b++) begin
            if (!d) begin
                check("bwe_high", int'(bwe), 1);
                do_words(words, 1'b0);
                lsq.push_back(flags);
            end
            repeat ($urandom_range(0, 3)) tick();
            if (b == err_blk) begin
                line_error_i = 1'b1;
                line_block_done_i = 1'b1;
                tick();
                line_error_i = 1'b0;
                line_block_done_i = 1'b0;
                check_idle("error");
                return;
            end
            line_block_done_i = 1'b1;
            tick();
            line_block_done_i = 1'b0;
            if (d) begin
                check("bre_high", int'(bre), 1);
                do_words(words, 1'b1);
            end
            if (be) bcq.push_back(16'(rem - 1));
            last = !m || (be && rem == 1);
            rem--;
            if (last) begin
                if (AcmdBuilt && m && ae) acq.push_back(flags);
                check("active_finish", int'({rta, wta}), flags);
                tick();
                check_idle("done");
                return;
            end
            if (d) lsq.push_back(flags);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_idle("abort_end");
    endtask

    initial begin
        int d, m, be, ae, cnt, sz, nblk, eb;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check_idle("reset");

        // Directed cases
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1, 512, 1, -1);
        run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 3, 4, 3, -1);
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1, 5, 1, -1);
        run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 1, 5, 1, -1);
        run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4, 8, 4, 1);
        run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4, 12, 4, 2);

        // Illegal starts
        block_size_i = 12'd0;
        multi_block_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_idle("illegal_size0");
        block_size_i = 12'd16;
        multi_block_i = 1'b1;
        block_count_enable_i = 1'b1;
        block_count_i = 16'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check_idle("illegal_count0");

        // Abort mid-WR_BUF with a coincident start and a stray word next cycle
        dir_read_i = 1'b0;
        multi_block_i = 1'b0;
        block_count_enable_i = 1'b0;
        block_size_i = 12'd16;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (2) begin
            word_access_i = 1'b1;
            tick();
            word_access_i = 1'b0;
        end
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        word_access_i = 1'b1;
        tick();
        word_access_i = 1'b0;
        check_idle("abort_mid");
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1, 16, 1, -1);

        // Randomised transfers
        for (int i = 0; i < 24; i++) begin
            d   = $urandom_range(0, 1);
            m   = $urandom_range(0, 1);
            be  = $urandom_range(0, 1);
            ae  = $urandom_range(0, 1);
            cnt = $urandom_range(1, 4);
            sz  = ($urandom_range(0, 7) == 0) ? $urandom_range(41, 600) : $urandom_range(1, 40);
            nblk = (m == 0) ? 1 : ((be != 0) ? cnt : $urandom_range(1, 3));
            eb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nblk - 1) : -1;
            run_xfer(d[0], m[0], be[0], ae[0], cnt, sz, nblk, eb);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check("line_start_pending", lsq.size(), 0);
        check("bc_pending", bcq.size(), 0);
        check("acmd_pending", acq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
